fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-low reset; 0 = reset.
REQ-004 npc  input  32  next fetch address from next-PC logic.
REQ-005 stall  input  1  hazard stall; holds PC and F/D register.
REQ-006 flush_D  input  1  replaces the instruction entering D with a bubble.
REQ-007 i_inst_rdata  input  32  instruction word returned combinationally for i_inst_addr.
REQ-008 i_inst_addr  output  32  instruction memory address; equals pc_F.
REQ-009 pc_F  output  32  current fetch PC.
REQ-010 instr_D  output  32  instruction held in F/D register.
REQ-011 pc_D  output  32  PC of instr_D.
REQ-012 valid_D  output  1  1 = instr_D is a real fetched instruction; 0 = bubble.
REQ-013 exc_adel_D  output  1  fetch address error flag for the instruction in D.

Function
REQ-014 PC register update priority: reset, then stall (hold), then load npc.
REQ-015 i_inst_addr and pc_F are driven directly from the PC register, with zero combinational delay from state.
REQ-016 F/D register update priority: reset, then flush_D (bubble), then stall (hold), then capture.
REQ-017 Capture: instr_D <= i_inst_rdata, pc_D <= pc_F, valid_D <= 1, exc_adel_D <= fetch error of pc_F.
REQ-018 Bubble: instr_D <= 32'h0000_0000 (nop), pc_D <= pc_F, valid_D <= 0, exc_adel_D <= 0.
REQ-019 Latency: an instruction at address A appears in D exactly one cycle after pc_F == A with stall low.
REQ-020 When stall and flush_D are both high: PC holds, D becomes a bubble, and the held PC is re-captured on the first cycle in which stall is low.
REQ-021 The branch delay slot is not squashed by this block; flush_D is driven only by external control.
REQ-022 PC arithmetic: 32-bit, no saturation; npc is taken verbatim, including wrap-around from 32'hFFFF_FFFC to 0.
REQ-023 While stall is held for N cycles, pc_F, instr_D, pc_D, valid_D and exc_adel_D are all unchanged for those N cycles.

Reset
REQ-024 On reset low at a clock edge: pc_F = 32'h0000_3000, instr_D = 0, pc_D = 32'h0000_3000, valid_D = 0, exc_adel_D = 0.
REQ-025 Reset overrides stall and flush_D in every cycle, including a reset asserted in the middle of a stall.
REQ-026 First cycle after reset release: fetch from 32'h0000_3000, with D still a bubble.

Configuration
REQ-027 Macro FETCH_ADEL_EN enables fetch address checking.
REQ-028 With FETCH_ADEL_EN defined, the fetch error is set when pc_F[1:0] != 0 or when pc_F is outside 32'h0000_3000..32'h0000_6FFC.
REQ-029 With FETCH_ADEL_EN defined, an erroneous capture sets exc_adel_D = 1, forces instr_D = 0, keeps pc_D = faulting PC, and sets valid_D = 1.
REQ-030 Without FETCH_ADEL_EN, exc_adel_D is constant 0, no address check logic is present, and i_inst_rdata is captured unmodified.

Verification
REQ-031 Reset scenario: reset=0 for 2 cycles with npc=0x4000 -> pc_F=0x3000 and valid_D=0; after release, next edge pc_F=0x4000 and pc_D=0x3000.
REQ-032 Sequential fetch scenario: npc=pc_F+4, rdata=pc_F^0xA5A5_0000 for 4 cycles -> instr_D/pc_D track one cycle behind, with valid_D=1.
REQ-033 Stall scenario: stall=1 for 3 cycles at pc_F=0x3008 -> pc_F stays 0x3008 and instr_D/pc_D are frozen; after release, pc_D=0x3008.
REQ-034 Stall plus flush scenario: stall=1 and flush_D=1 for one cycle at pc_F=0x300C -> instr_D=0 and valid_D=0 with pc_F=0x300C; the next cycle (stall=0) gives pc_D=0x300C and valid_D=1.
REQ-035 Address error scenario (FETCH_ADEL_EN): npc=0x3002 -> next capture gives exc_adel_D=1, instr_D=0, pc_D=0x3002; npc=0x7000 likewise; without the macro, exc_adel_D stays 0.
REQ-036 Mid-stall reset scenario: reset=0 during stall=1 at pc_F=0x5000 -> pc_F=0x3000, valid_D=0 on that edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory bus, control inputs and F/D outputs.
interface fetch_stage_if;
    logic [31:0] npc;
    logic        stall;
    logic        flush_D;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] pc_F;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic        valid_D;
    logic        exc_adel_D;

    modport master (
        input  npc,
        input  stall,
        input  flush_D,
        input  i_inst_rdata,
        output i_inst_addr,
        output pc_F,
        output instr_D,
        output pc_D,
        output valid_D,
        output exc_adel_D
    );

    modport slave (
        output npc,
        output stall,
        output flush_D,
        output i_inst_rdata,
        input  i_inst_addr,
        input  pc_F,
        input  instr_D,
        input  pc_D,
        input  valid_D,
        input  exc_adel_D
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC register plus F/D pipeline register with stall/flush control.
// Define FETCH_ADEL_EN to flag misaligned or out-of-range fetch addresses.
module fetch_stage (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_dec;
    logic        valid;
    logic [31:0] capture_instr;

    assign bus.i_inst_addr = pc;
    assign bus.pc_F        = pc;
    assign bus.instr_D     = instr;
    assign bus.pc_D        = pc_dec;
    assign bus.valid_D     = valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (!bus.stall) begin
            pc <= bus.npc;
        end
    end

`ifdef FETCH_ADEL_EN
    localparam logic [31:0] TEXT_LO = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI = 32'h0000_6FFC;

    logic fetch_err;
    logic exc;

    // A faulting fetch still enters D as a valid slot so the exception can be raised there.
    always_comb begin
        fetch_err     = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
        capture_instr = fetch_err ? 32'h0000_0000 : bus.i_inst_rdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            exc <= 1'b0;
        end else if (bus.flush_D) begin
            exc <= 1'b0;
        end else if (!bus.stall) begin
            exc <= fetch_err;
        end
    end

    assign bus.exc_adel_D = exc;
`else
    assign capture_instr  = bus.i_inst_rdata;
    assign bus.exc_adel_D = 1'b0;
`endif

    // Flush wins over stall so a stalled slot can be replaced by a bubble while the PC holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr  <= 32'h0000_0000;
            pc_dec <= RESET_PC;
            valid  <= 1'b0;
        end else if (bus.flush_D) begin
            instr  <= 32'h0000_0000;
            pc_dec <= pc;
            valid  <= 1'b0;
        end else if (!bus.stall) begin
            instr  <= capture_instr;
            pc_dec <= pc;
            valid  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   assert_count;
    int   fail_count;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef FETCH_ADEL_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    function automatic bit addr_bad(input logic [31:0] addr);
        if (!ADEL) return 1'b0;
        return (addr % 4 != 0) || (addr < 32'h3000) || (addr > 32'h6FFC);
    endfunction

    // Instruction memory answers combinationally for whatever address is presented.
    assign bus.i_inst_rdata = mem_word(bus.i_inst_addr);

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_valid;
    logic        m_exc;
    bit          model_known = 1'b0;

    // Reference: D holds what was at the fetch PC one edge ago unless held or bubbled.
    always @(posedge clk) begin
        logic [31:0] fetched;
        if (!reset) begin
            m_pc = 32'h3000; m_instr = 0; m_pcd = 32'h3000; m_valid = 0; m_exc = 0;
            model_known = 1'b1;
        end else if (model_known) begin
            fetched = m_pc;
            if (bus.flush_D) begin
                m_instr = 0; m_pcd = fetched; m_valid = 0; m_exc = 0;
            end else if (!bus.stall) begin
                m_exc   = addr_bad(fetched);
                m_instr = m_exc ? 32'h0 : mem_word(fetched);
                m_pcd   = fetched;
                m_valid = 1'b1;
            end
            if (!bus.stall) m_pc = bus.npc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (model_known) begin
            checkOutput("model.pc_F", bus.pc_F, m_pc);
            checkOutput("model.i_inst_addr", bus.i_inst_addr, m_pc);
            checkOutput("model.instr_D", bus.instr_D, m_instr);
            checkOutput("model.pc_D", bus.pc_D, m_pcd);
            checkOutput("model.valid_D", {31'b0, bus.valid_D}, {31'b0, m_valid});
            checkOutput("model.exc_adel_D", {31'b0, bus.exc_adel_D}, {31'b0, m_exc});
        end
    end

    task automatic applyStimulus(input logic [31:0] npc, input logic stall,
                                 input logic flush, input logic rst_n);
        bus.npc     = npc;
        bus.stall   = stall;
        bus.flush_D = flush;
        reset       = rst_n;
        @(posedge clk);
        #2;
    endtask

    task automatic checkD(input string tag, input logic [31:0] pcf, input logic [31:0] ins,
                          input logic [31:0] pcd, input logic vld, input logic exc);
        checkOutput({tag, ".pc_F"}, bus.pc_F, pcf);
        checkOutput({tag, ".instr_D"}, bus.instr_D, ins);
        checkOutput({tag, ".pc_D"}, bus.pc_D, pcd);
        checkOutput({tag, ".valid_D"}, {31'b0, bus.valid_D}, {31'b0, vld});
        checkOutput({tag, ".exc_adel_D"}, {31'b0, bus.exc_adel_D}, {31'b0, exc});
    endtask

    initial begin
        logic [31:0] npc;
        int          r;
        assert_count = 0;
        fail_count   = 0;
        bus.npc = 32'h4000; bus.stall = 0; bus.flush_D = 0; reset = 0;

        applyStimulus(32'h4000, 0, 0, 0);
        applyStimulus(32'h4000, 0, 0, 0);
        checkD("reset", 32'h3000, 32'h0, 32'h3000, 0, 0);
        applyStimulus(32'h4000, 0, 0, 1);
        checkD("release", 32'h4000, 32'hA5A5_3000, 32'h3000, 1, 0);

        applyStimulus(32'h3000, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h3004 + 32'(i) * 4, 0, 0, 1);
            checkD("seq", 32'h3004 + 32'(i) * 4, 32'hA5A5_3000 + 32'(i) * 4,
                   32'h3000 + 32'(i) * 4, 1, 0);
        end
        applyStimulus(32'h3008, 0, 0, 1);
        checkD("jump", 32'h3008, 32'hA5A5_3010, 32'h3010, 1, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h300C, 1, 0, 1);
            checkD("stall", 32'h3008, 32'hA5A5_3010, 32'h3010, 1, 0);
        end
        applyStimulus(32'h300C, 0, 0, 1);
        checkD("unstall", 32'h300C, 32'hA5A5_3008, 32'h3008, 1, 0);

        applyStimulus(32'h3010, 1, 1, 1);
        checkD("stallflush", 32'h300C, 32'h0, 32'h300C, 0, 0);
        applyStimulus(32'h3010, 0, 0, 1);
        checkD("recapture", 32'h3010, 32'hA5A5_300C, 32'h300C, 1, 0);

        applyStimulus(32'h3002, 0, 0, 1);
        applyStimulus(32'h3004, 0, 0, 1);
        checkD("misalign", 32'h3004, ADEL ? 32'h0 : 32'hA5A5_3002, 32'h3002, 1, ADEL);
        applyStimulus(32'h7000, 0, 0, 1);
        applyStimulus(32'h3000, 0, 0, 1);
        checkD("outrange", 32'h3000, ADEL ? 32'h0 : 32'hA5A5_7000, 32'h7000, 1, ADEL);

        applyStimulus(32'hFFFF_FFFC, 0, 0, 1);
        applyStimulus(32'h0000_0000, 0, 0, 1);
        checkD("wrap", 32'h0, ADEL ? 32'h0 : 32'h5A5A_FFFC, 32'hFFFF_FFFC, 1, ADEL);

        applyStimulus(32'h5000, 0, 0, 1);
        applyStimulus(32'h5004, 1, 0, 1);
        checkOutput("midstall.hold", bus.pc_F, 32'h5000);
        applyStimulus(32'h5004, 1, 0, 0);
        checkD("midstall.reset", 32'h3000, 32'h0, 32'h3000, 0, 0);

        for (int cyc = 0; cyc < 400; cyc++) begin
            r = int'($urandom_range(0, 15));
            if (r <= 8)       npc = m_pc + 4;
            else if (r <= 11) npc = 32'h3000 + ($urandom_range(0, 16383) << 2);
            else if (r == 12) npc = m_pc + $urandom_range(1, 3);
            else if (r == 13) npc = 32'hFFFF_FFFC;
            else              npc = $urandom;
            applyStimulus(npc, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 39) != 0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
